preg_release_queue: RTL

- Commit-side producer for the physical-register free list. Accepts up to two retired old-physical-register tags per cycle from ROB commit.
- Buffers the tags in a FIFO and drains them one per cycle as free_en/free_phys pulses into the free list's single release port.
- Provides commit backpressure and sticky error flags for overflow and double-free.

---
 rtl/preg_release_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/preg_release_queue.sv
// rtl/preg_release_queue.sv - commit-side release FIFO feeding the physical-register free list
module preg_release_queue #(
    parameter int PHYS_REGS = 64,
    parameter int DEPTH     = 16,
    localparam int TW = $clog2(PHYS_REGS),
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rel0_valid,
    input  logic [TW-1:0] rel0_phys,
    input  logic          rel1_valid,
    input  logic [TW-1:0] rel1_phys,
    output logic          rel_ready,
    output logic          free_en,
    output logic [TW-1:0] free_phys,
    output logic [CW-1:0] occupancy,
    output logic          empty,
    output logic          ovf_err,
    output logic          dup_err
);

    logic [TW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PHYS_REGS-1:0] pending_q, pending_d;
    logic                 free_en_q;
    logic [TW-1:0]        free_phys_q;
    logic                 ovf_err_q, dup_err_q;

    logic          pop;
    logic          any_valid;
    logic          same_tag;
    logic          acc0, acc1;
    logic          dup0, dup1;
    logic          ovf;
    logic [1:0]    n_acc;
    logic [AW-1:0] wr1_addr;
    logic [TW-1:0] pop_tag;

    // Two free slots are needed so commit never has to split a retire pair.
    assign rel_ready = (count_q <= CW'(DEPTH - 2));
    assign occupancy = count_q;
    assign empty     = (count_q == '0);
    assign free_en   = free_en_q;
    assign free_phys = free_phys_q;
    assign ovf_err   = ovf_err_q;
    assign dup_err   = dup_err_q;

    // Accept/drop decisions use the pre-edge pending mask, so a tag leaving this cycle still counts as pending.
    always_comb begin
        any_valid = rel0_valid | rel1_valid;
        same_tag  = rel0_valid & rel1_valid & (rel0_phys == rel1_phys);
        pop       = (count_q != '0);
        pop_tag   = mem_q[rd_ptr_q];
        ovf       = any_valid & ~rel_ready;
        acc0      = rel_ready & rel0_valid & ~pending_q[rel0_phys];
        dup0      = rel_ready & rel0_valid &  pending_q[rel0_phys];
        acc1      = rel_ready & rel1_valid & ~pending_q[rel1_phys] & ~same_tag;
        dup1      = rel_ready & rel1_valid & (pending_q[rel1_phys] | same_tag);
        n_acc     = {1'b0, acc0} + {1'b0, acc1};
        wr1_addr  = wr_ptr_q + AW'(acc0);
        wr_ptr_d  = wr_ptr_q + AW'(n_acc);
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(n_acc) - CW'(pop);
        pending_d = pending_q;
        if (pop) begin
            pending_d[pop_tag] = 1'b0;
        end
        if (acc0) begin
            pending_d[rel0_phys] = 1'b1;
        end
        if (acc1) begin
            pending_d[rel1_phys] = 1'b1;
        end
    end

    // Tag storage; stale contents after reset are harmless because the pointers and count restart.
    always_ff @(posedge clk) begin
        if (acc0) begin
            mem_q[wr_ptr_q] <= rel0_phys;
        end
        if (acc1) begin
            mem_q[wr1_addr] <= rel1_phys;
        end
    end

    // Pointers, count, pending mask, registered release pulse and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            free_en_q   <= 1'b0;
            free_phys_q <= '0;
            ovf_err_q   <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            free_en_q   <= pop;
            free_phys_q <= pop ? pop_tag : '0;
            if (ovf) begin
                ovf_err_q <= 1'b1;
            end
            if (dup0 | dup1) begin
                dup_err_q <= 1'b1;
            end
        end
    end

endmodule
